// File: rtl/scroll_ctrl.sv
// Two-colour LED scroller: a 3-lit window sweeps right on the red bar, then back
// on the green bar at half speed, with start/pause/stop control and 4 speed levels.
module scroll_ctrl #(
  parameter int BASE_CYC = 1048576,
  parameter int TICK_W   = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_stop,
  input  logic       speed_up,
  input  logic       speed_down,
  output logic [7:0] shift_red,
  output logic [7:0] shift_green,
  output logic       direction,
  output logic       step,
  output logic       busy,
  output logic [1:0] speed
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_p;
  logic [TICK_W-1:0] r_cnt;
  logic [1:0]        r_speed;

  logic              w_dir;
  logic [2:0]        w_shift;
  logic [TICK_W:0]   w_interval;
  logic [TICK_W:0]   w_last;
  logic              w_adv;
  logic [3:0]        w_p_adv;
  logic [7:0]        w_pat;

  // Interval = BASE_CYC << (3 - speed), doubled on the green return sweep.
  always_comb begin
    w_dir      = (r_p >= 4'd6);
    w_shift    = {1'b0, ~r_speed} + {2'b00, w_dir};
    w_interval = (TICK_W+1)'(BASE_CYC) << w_shift;
    w_last     = w_interval - {{TICK_W{1'b0}}, 1'b1};
    // '>=' so a speed increase that overtakes the counter still advances at once
    w_adv      = (r_state == S_RUN) && !btn_stop && ({1'b0, r_cnt} >= w_last);
    w_p_adv    = (r_p == 4'd10) ? 4'd1 : r_p + 4'd1;
  end

  always_comb begin
    case (r_p)
      4'd0:    w_pat = 8'b1110_0000;
      4'd1:    w_pat = 8'b0111_0000;
      4'd2:    w_pat = 8'b0011_1000;
      4'd3:    w_pat = 8'b0001_1100;
      4'd4:    w_pat = 8'b0000_1110;
      4'd5:    w_pat = 8'b0000_0111;
      4'd6:    w_pat = 8'b0000_1110;
      4'd7:    w_pat = 8'b0001_1100;
      4'd8:    w_pat = 8'b0011_1000;
      4'd9:    w_pat = 8'b0111_0000;
      4'd10:   w_pat = 8'b1110_0000;
      default: w_pat = 8'b0000_0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Only the highest-priority pulse present is considered (stop > pause > start).
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (btn_start && !btn_pause && !btn_stop) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (btn_stop) begin
          w_state_next = S_IDLE;
        end else if (btn_pause) begin
          w_state_next = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (btn_stop) begin
          w_state_next = S_IDLE;
        end else if (btn_pause) begin
          w_state_next = S_RUN;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (r_state != S_IDLE);
    step        = w_adv;
    direction   = busy && w_dir;
    shift_red   = (busy && !w_dir) ? w_pat : 8'h00;
    shift_green = (busy && w_dir) ? w_pat : 8'h00;
    speed       = r_speed;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p   <= 4'd0;
      r_cnt <= '0;
    end else if (w_state_next == S_IDLE) begin
      r_p   <= 4'd0;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      if (w_adv) begin
        r_p   <= w_p_adv;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + {{(TICK_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_speed <= 2'd0;
    end else if (speed_up && !speed_down && r_speed != 2'd3) begin
      r_speed <= r_speed + 2'd1;
    end else if (speed_down && !speed_up && r_speed != 2'd0) begin
      r_speed <= r_speed - 2'd1;
    end
  end

endmodule

// File: tb/tb_scroll_ctrl.sv
// Randomized + directed bench for scroll_ctrl: a cycle-level reference model queues
// the expected outputs for each cycle and a negedge monitor compares them.
module tb_scroll_ctrl;

  localparam int BASE = 4;
  localparam int TW   = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_start = 1'b0, btn_pause = 1'b0, btn_stop = 1'b0;
  logic       speed_up = 1'b0, speed_down = 1'b0;
  logic [7:0] shift_red, shift_green;
  logic       direction, step, busy;
  logic [1:0] speed;

  always #5 clk = ~clk;

  scroll_ctrl #(.BASE_CYC(BASE), .TICK_W(TW)) dut (
    .clk(clk), .reset(reset),
    .btn_start(btn_start), .btn_pause(btn_pause), .btn_stop(btn_stop),
    .speed_up(speed_up), .speed_down(speed_down),
    .shift_red(shift_red), .shift_green(shift_green),
    .direction(direction), .step(step), .busy(busy), .speed(speed)
  );

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic       dir;
    logic       stp;
    logic       bsy;
    logic [1:0] spd;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: st 0=idle 1=run 2=pause, p = pattern index, cnt = clocks into interval
  int         m_st = 0, m_p = 0, m_cnt = 0, m_spd = 0;
  logic [7:0] pat [0:10];

  initial begin
    pat = '{8'hE0, 8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0};
  end

  function automatic int interval_of(input int spd, input int p);
    return BASE * (8 >> spd) * ((p >= 6) ? 2 : 1);
  endfunction

  task automatic cyc(input bit s, input bit pa, input bit st, input bit u, input bit d,
                     input bit rn = 1'b1);
    exp_t e;
    int   iv;
    bit   adv;
    @(posedge clk);
    #1;
    btn_start = s; btn_pause = pa; btn_stop = st; speed_up = u; speed_down = d;
    reset = rn;
    if (!rn) begin
      m_st = 0; m_p = 0; m_cnt = 0; m_spd = 0;
    end
    iv      = interval_of(m_spd, m_p);
    adv     = (m_st == 1) && !st && (m_cnt >= iv - 1);
    e.red   = (m_st != 0 && m_p < 6) ? pat[m_p] : 8'h00;
    e.green = (m_st != 0 && m_p >= 6) ? pat[m_p] : 8'h00;
    e.dir   = (m_st != 0 && m_p >= 6);
    e.stp   = adv;
    e.bsy   = (m_st != 0);
    e.spd   = 2'(m_spd);
    exp_q.push_back(e);
    if (rn) begin
      if (m_st == 1) begin
        if (adv) begin
          m_cnt = 0;
          m_p   = (m_p == 10) ? 1 : m_p + 1;
        end else begin
          m_cnt++;
        end
      end
      if (st) begin
        m_st = 0;
      end else if (pa) begin
        if (m_st == 1) m_st = 2;
        else if (m_st == 2) m_st = 1;
      end else if (s && m_st == 0) begin
        m_st = 1;
      end
      if (m_st == 0) begin
        m_p = 0; m_cnt = 0;
      end
      if (u && !d && m_spd < 3) m_spd++;
      else if (d && !u && m_spd > 0) m_spd--;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic expired(input string what);
    miscompares++;
    $display("FAIL wait_%s: condition not reached within budget, required reached", what);
  endtask

  always @(negedge clk) begin
    exp_t e, a;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a.red = shift_red; a.green = shift_green; a.dir = direction;
      a.stp = step; a.bsy = busy; a.spd = speed;
      vectors++;
      if (a !== e) begin
        miscompares++;
        if (miscompares <= 20)
          $display("FAIL outputs t=%0t got red=%h green=%h dir=%b step=%b busy=%b speed=%0d required red=%h green=%h dir=%b step=%b busy=%b speed=%0d",
                   $time, a.red, a.green, a.dir, a.stp, a.bsy, a.spd,
                   e.red, e.green, e.dir, e.stp, e.bsy, e.spd);
      end
    end
  end

  initial begin
    int budget;
    repeat (3) cyc(0, 0, 0, 0, 0, 1'b0);
    idle(2);

    // speed saturation, cancelling pulses, full sweep at speed 3
    repeat (5) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 0);
    idle(80);

    // asynchronous reset while the green sweep is at p7
    budget = 200;
    while (m_p != 7 && budget > 0) begin idle(1); budget--; end
    if (budget == 0) expired("p7");
    repeat (2) cyc(0, 0, 0, 0, 0, 1'b0);
    idle(3);

    // speed 0: 32-clock red and 64-clock green intervals
    cyc(1, 0, 0, 0, 0);
    idle(560);
    cyc(0, 0, 1, 0, 0);

    // pause with the counter held at 2 in p3, resume at speed 3
    repeat (3) cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    budget = 200;
    while (!(m_p == 3 && m_cnt == 1) && budget > 0) begin idle(1); budget--; end
    if (budget == 0) expired("p3");
    cyc(0, 1, 0, 0, 0);
    idle(20);
    cyc(0, 1, 0, 0, 0);
    idle(10);

    // same-cycle pulse priority
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    idle(3);
    cyc(1, 0, 0, 0, 0);
    idle(5);
    cyc(0, 1, 1, 0, 0);
    idle(3);

    // speed raised three times while counter sits at 20 in a red speed-0 interval
    repeat (3) cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    budget = 200;
    while (!(m_p < 5 && m_cnt == 20) && budget > 0) begin idle(1); budget--; end
    if (budget == 0) expired("cnt20");
    repeat (3) cyc(0, 0, 0, 1, 0);
    idle(5);
    cyc(0, 0, 1, 0, 0);

    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0,
          $urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 59) == 0, $urandom_range(0, 999) != 0);
    end
    idle(2);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
